// File: rtl/sm_seq_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : sm_seq_arith_unit
// Brief    : Sign-magnitude ADD/SUB (single cycle), MUL/DIV (iterative).
// Revision : 1.0
// ============================================================================
module sm_seq_arith_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Y,
  output logic [W-1:0] R,
  output logic         Z,
  output logic         V,
  output logic         N,
  output logic         C
);

  localparam int M  = W - 1;
  localparam int CW = $clog2(W);

  localparam logic [1:0]    c_OP_ADD = 2'b00;
  localparam logic [1:0]    c_OP_SUB = 2'b01;
  localparam logic [1:0]    c_OP_MUL = 2'b10;
  localparam logic [1:0]    c_OP_DIV = 2'b11;
  localparam logic [CW-1:0] c_ITER   = CW'(W - 1);
  localparam logic [CW-1:0] c_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic          r_sa;
  logic          r_sb;
  logic [M-1:0]  r_ma;
  logic [M-1:0]  r_mb;
  logic [M-1:0]  r_hi;
  logic [M-1:0]  r_lo;
  logic [CW-1:0] r_cnt;

  // Operand sign is dropped when the magnitude is zero, so -0 behaves as +0.
  logic w_a_sgn;
  logic w_b_sgn;
  logic w_a_short;
  assign w_a_sgn   = A[W-1] & (|A[W-2:0]);
  assign w_b_sgn   = B[W-1] & (|B[W-2:0]);
  assign w_a_short = (op == c_OP_ADD) || (op == c_OP_SUB) ||
                     ((op == c_OP_DIV) && (B[W-2:0] == '0));

  // One shift-add step: {hi,lo} holds the partial product, lo the multiplier.
  logic [M:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : '0);

  // One restoring-division step: hi is the partial remainder, lo the dividend/quotient.
  logic [M:0]   w_div_sh;
  logic         w_div_ge;
  logic [M-1:0] w_div_rem;
  assign w_div_sh  = {r_hi, r_lo[M-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_mb});
  assign w_div_rem = w_div_ge ? (w_div_sh[M-1:0] - r_mb) : w_div_sh[M-1:0];

  logic         w_b_eff;
  logic [M:0]   w_sum;
  logic         w_a_ge_b;
  logic [M-1:0] w_a_minus_b;
  logic [M-1:0] w_b_minus_a;
  assign w_b_eff     = r_sb ^ (r_op == c_OP_SUB);
  assign w_sum       = {1'b0, r_ma} + {1'b0, r_mb};
  assign w_a_ge_b    = (r_ma >= r_mb);
  assign w_a_minus_b = r_ma - r_mb;
  assign w_b_minus_a = r_mb - r_ma;

  logic         w_ysgn;
  logic [M-1:0] w_ymag;
  logic         w_rsgn;
  logic [M-1:0] w_rmag;
  logic         w_v;
  logic         w_c;
  logic [W-1:0] w_y;
  logic [W-1:0] w_r;

  always_comb begin
    w_ysgn = 1'b0;
    w_ymag = '0;
    w_rsgn = 1'b0;
    w_rmag = '0;
    w_v    = 1'b0;
    w_c    = 1'b0;
    case (r_op)
      c_OP_ADD, c_OP_SUB: begin
        if (r_sa == w_b_eff) begin
          w_ysgn = r_sa;
          w_ymag = w_sum[M-1:0];
          w_v    = w_sum[M];
          w_c    = w_sum[M];
        end else if (w_a_ge_b) begin
          w_ysgn = r_sa;
          w_ymag = w_a_minus_b;
          w_c    = 1'b1;
        end else begin
          w_ysgn = w_b_eff;
          w_ymag = w_b_minus_a;
        end
      end
      c_OP_MUL: begin
        w_ysgn = r_sa ^ r_sb;
        w_ymag = r_lo;
        w_rmag = r_hi;
        w_v    = |r_hi;
      end
      default: begin
        if (r_mb == '0) begin
          w_rsgn = r_sa;
          w_rmag = r_ma;
          w_v    = 1'b1;
        end else begin
          w_ysgn = r_sa ^ r_sb;
          w_ymag = r_lo;
          w_rsgn = r_sa;
          w_rmag = r_hi;
        end
      end
    endcase
  end

  // Zero magnitudes always carry a positive sign.
  assign w_y = {w_ysgn & (|w_ymag), w_ymag};
  assign w_r = {w_rsgn & (|w_rmag), w_rmag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= c_OP_ADD;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Y       <= '0;
      R       <= '0;
      Z       <= 1'b0;
      V       <= 1'b0;
      N       <= 1'b0;
      C       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !done) begin
            r_op <= op;
            r_sa <= w_a_sgn;
            r_sb <= w_b_sgn;
            r_ma <= A[W-2:0];
            r_mb <= B[W-2:0];
            if (w_a_short) begin
              r_state <= S_FIN;
            end else begin
              r_cnt   <= c_ITER;
              r_hi    <= '0;
              r_lo    <= (op == c_OP_DIV) ? A[W-2:0] : B[W-2:0];
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          busy  <= 1'b1;
          r_cnt <= r_cnt - c_ONE;
          if (r_op == c_OP_MUL) begin
            r_hi <= w_mul_sum[M:1];
            r_lo <= {w_mul_sum[0], r_lo[M-1:1]};
          end else begin
            r_hi <= w_div_rem;
            r_lo <= {r_lo[M-2:0], w_div_ge};
          end
          if (r_cnt == c_ONE) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          Y       <= w_y;
          R       <= w_r;
          Z       <= ~(|w_ymag);
          N       <= w_y[W-1];
          V       <= w_v;
          C       <= w_c;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_seq_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_seq_arith_unit
// Brief    : Directed self-checking bench for sm_seq_arith_unit at W=8.
// Revision : 1.0
// ============================================================================
module tb_sm_seq_arith_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] Y;
  logic [7:0] R;
  logic       Z;
  logic       V;
  logic       N;
  logic       C;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int nb;
  int ndone;

  sm_seq_arith_unit #(.W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .R     (R),
    .Z     (Z),
    .V     (V),
    .N     (N),
    .C     (C)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, then waits (bounded) for done; extra_start pulses
  // start again three cycles into the operation.
  task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit extra_start, output int l, output int nbusy);
    @(posedge clk); #1;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    nbusy = 0;
    while (!done && l < 40) begin
      @(posedge clk); #1;
      l++;
      if (busy) nbusy++;
      if (extra_start && l == 3) begin
        op = 2'b00; A = 8'h11; B = 8'h22; start = 1'b1;
      end
      if (extra_start && l == 4) start = 1'b0;
    end
  endtask

  task automatic chk_done_pulse(input string tag);
    @(posedge clk); #1;
    chk(tag, {31'd0, done}, 32'd0);
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_Y", {24'd0, Y}, 32'h00);
    chk("rst_R", {24'd0, R}, 32'h00);
    chk("rst_flags", {28'd0, Z, V, N, C}, 32'h0);
    rst = 1'b0;

    do_op(2'b00, 8'h05, 8'h83, 1'b0, lat, nb);
    chk("add_Y", {24'd0, Y}, 32'h02);
    chk("add_R", {24'd0, R}, 32'h00);
    chk("add_flags", {28'd0, Z, V, N, C}, 32'b0001);
    chk("add_lat", lat, 1);
    chk("add_busy", nb, 0);
    chk_done_pulse("add_done_width");

    do_op(2'b01, 8'h03, 8'h05, 1'b0, lat, nb);
    chk("sub_Y", {24'd0, Y}, 32'h82);
    chk("sub_R", {24'd0, R}, 32'h00);
    chk("sub_flags", {28'd0, Z, V, N, C}, 32'b0010);

    do_op(2'b00, 8'h7F, 8'h01, 1'b0, lat, nb);
    chk("addovf_Y", {24'd0, Y}, 32'h00);
    chk("addovf_flags", {28'd0, Z, V, N, C}, 32'b1101);

    do_op(2'b10, 8'h8C, 8'h0B, 1'b1, lat, nb);
    chk("mul_Y", {24'd0, Y}, 32'h84);
    chk("mul_R", {24'd0, R}, 32'h01);
    chk("mul_flags", {28'd0, Z, V, N, C}, 32'b0110);
    chk("mul_lat", lat, 8);
    chk("mul_busy", nb, 7);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mul_ignored_start", ndone, 0);
    chk("mul_Y_hold", {24'd0, Y}, 32'h84);

    do_op(2'b11, 8'h64, 8'h87, 1'b0, lat, nb);
    chk("div_Y", {24'd0, Y}, 32'h8E);
    chk("div_R", {24'd0, R}, 32'h02);
    chk("div_flags", {28'd0, Z, V, N, C}, 32'b0010);
    chk("div_lat", lat, 8);

    do_op(2'b11, 8'h82, 8'h05, 1'b0, lat, nb);
    chk("div2_Y", {24'd0, Y}, 32'h00);
    chk("div2_R", {24'd0, R}, 32'h82);
    chk("div2_flags", {28'd0, Z, V, N, C}, 32'b1000);

    do_op(2'b11, 8'h25, 8'h80, 1'b0, lat, nb);
    chk("dz_Y", {24'd0, Y}, 32'h00);
    chk("dz_R", {24'd0, R}, 32'h25);
    chk("dz_flags", {28'd0, Z, V, N, C}, 32'b1100);
    chk("dz_lat", lat, 1);
    chk("dz_busy", nb, 0);

    // Reset three cycles into a multiply.
    @(posedge clk); #1;
    op = 2'b10; A = 8'h8C; B = 8'h0B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_Y", {24'd0, Y}, 32'h00);
    chk("rstmid_R", {24'd0, R}, 32'h00);
    chk("rstmid_flags", {28'd0, Z, V, N, C}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rstmid_no_done", ndone, 0);

    do_op(2'b00, 8'h01, 8'h01, 1'b0, lat, nb);
    chk("post_add_Y", {24'd0, Y}, 32'h02);
    chk("post_add_flags", {28'd0, Z, V, N, C}, 32'b0000);
    chk("post_add_lat", lat, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
